// File: rtl/vga_scan_controller.sv
// VGA raster sequencer: pixel divider, x/y scan counters, per-line prefetch
// handshake with underrun detection, and a run/stop FSM with frame-aligned stop.
module vga_scan_controller #(
    parameter int X_RES         = 640,
    parameter int Y_RES         = 480,
    parameter int H_FRONT_PORCH = 16,
    parameter int H_SYNC        = 96,
    parameter int H_BACK_PORCH  = 48,
    parameter int V_FRONT_PORCH = 10,
    parameter int V_SYNC        = 2,
    parameter int V_BACK_PORCH  = 33,
    parameter int CLK_DIV       = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic       fetch_ack,
    input  logic       underrun_clear,
    output logic       pixel_tick,
    output logic [9:0] pixel_position_x,
    output logic [9:0] pixel_position_y,
    output logic       line_start,
    output logic       frame_start,
    output logic       fetch_req,
    output logic [9:0] fetch_line,
    output logic       underrun_flag,
    output logic       running
);

    localparam int H_TOTAL = X_RES + H_FRONT_PORCH + H_SYNC + H_BACK_PORCH;
    localparam int V_TOTAL = Y_RES + V_FRONT_PORCH + V_SYNC + V_BACK_PORCH;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [9:0]       X_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0]       Y_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0]       X_FETCH  = 10'(X_RES);
    localparam logic [10:0]      Y_ACTIVE = 11'(Y_RES);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        STOPPING
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic [DIV_W-1:0] div_cnt;
    logic             primed;
    logic             tick;
    logic             at_end;
    logic             stop_now;
    logic [9:0]       x_nx;
    logic [9:0]       y_nx;
    logic [10:0]      y_inc;
    logic             ls_nx;
    logic             fs_nx;
    logic             issue;
    logic [9:0]       line_nx;
    logic             accept;
    logic             cancel;

    // primed=0 means the next tick loads the origin rather than advancing
    assign tick     = (state != IDLE) && (div_cnt == DIV_LAST);
    assign at_end   = primed && (pixel_position_x == X_LAST)
                      && (pixel_position_y == Y_LAST);
    assign stop_now = tick && (state == STOPPING) && !enable && at_end;
    assign y_inc    = {1'b0, pixel_position_y} + 11'd1;

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:     if (enable) state_nx = RUN;
            RUN:      if (!enable) state_nx = STOPPING;
            STOPPING: begin
                if (enable)        state_nx = RUN;
                else if (stop_now) state_nx = IDLE;
            end
            default:  state_nx = IDLE;
        endcase
    end

    always_comb begin
        x_nx = pixel_position_x;
        y_nx = pixel_position_y;
        if (!primed) begin
            x_nx = '0;
            y_nx = '0;
        end else if (pixel_position_x == X_LAST) begin
            x_nx = '0;
            y_nx = (pixel_position_y == Y_LAST) ? 10'd0 : y_inc[9:0];
        end else begin
            x_nx = pixel_position_x + 10'd1;
        end
    end

    assign ls_nx = (x_nx == 10'd0) && ({1'b0, y_nx} < Y_ACTIVE);
    assign fs_nx = (x_nx == 10'd0) && (y_nx == 10'd0);

    // Prefetch the next active line as the current one leaves active video
    always_comb begin
        issue   = 1'b0;
        line_nx = '0;
        if (tick && primed && (x_nx == X_FETCH)) begin
            if (y_inc < Y_ACTIVE) begin
                issue   = 1'b1;
                line_nx = y_inc[9:0];
            end else if ((pixel_position_y == Y_LAST) && (state_nx == RUN)) begin
                issue   = 1'b1;
                line_nx = '0;
            end
        end
    end

    assign accept = fetch_req && fetch_ack;
    assign cancel = fetch_req && !fetch_ack && line_start
                    && (pixel_position_y == fetch_line);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt          <= '0;
            primed           <= 1'b0;
            pixel_tick       <= 1'b0;
            pixel_position_x <= '0;
            pixel_position_y <= '0;
            line_start       <= 1'b0;
            frame_start      <= 1'b0;
            running          <= 1'b0;
        end else begin
            running     <= (state_nx != IDLE);
            pixel_tick  <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            if ((state == IDLE) || stop_now) begin
                div_cnt          <= '0;
                primed           <= 1'b0;
                pixel_position_x <= '0;
                pixel_position_y <= '0;
            end else if (tick) begin
                div_cnt          <= '0;
                primed           <= 1'b1;
                pixel_tick       <= 1'b1;
                pixel_position_x <= x_nx;
                pixel_position_y <= y_nx;
                line_start       <= ls_nx;
                frame_start      <= fs_nx;
            end else begin
                div_cnt <= div_cnt + DIV_ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_req  <= 1'b0;
            fetch_line <= '0;
        end else if ((state == IDLE) || stop_now) begin
            fetch_req <= 1'b0;
        end else if (issue) begin
            fetch_req  <= 1'b1;
            fetch_line <= line_nx;
        end else if (accept || cancel) begin
            fetch_req <= 1'b0;
        end
    end

    // A new underrun outranks a simultaneous clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)              underrun_flag <= 1'b0;
        else if (cancel)         underrun_flag <= 1'b1;
        else if (underrun_clear) underrun_flag <= 1'b0;
    end

endmodule

// File: tb/tb_vga_scan_controller.sv
// Scoreboard bench: two scan controllers (CLK_DIV=2 reduced raster,
// CLK_DIV=1 tiny raster) checked against tick and fetch expectation queues.
module tb_vga_scan_controller;

    localparam int AXR = 16, AYR = 8, AHF = 2, AHS = 3, AHB = 2;
    localparam int AVF = 2, AVS = 1, AVB = 2, ACD = 2;
    localparam int AHT = AXR + AHF + AHS + AHB;
    localparam int AVT = AYR + AVF + AVS + AVB;
    localparam int AFR = AHT * AVT;
    localparam int BXR = 4, BYR = 2, BCD = 1;
    localparam int BHT = BXR + 3, BVT = BYR + 3, BFR = BHT * BVT;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic       ls;
        logic       fs;
    } tick_t;

    typedef struct packed {
        logic [9:0] line;
        logic [9:0] y;
    } fetch_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic       rst_a_n, en_a, ack_a, clr_a;
    logic       tick_a, ls_a, fs_a, req_a, uf_a, run_a;
    logic [9:0] xa, ya, line_a;
    logic       rst_b_n, en_b, ack_b, clr_b;
    logic       tick_b, ls_b, fs_b, req_b, uf_b, run_b;
    logic [9:0] xb, yb, line_b;

    vga_scan_controller #(
        .X_RES(AXR), .Y_RES(AYR), .H_FRONT_PORCH(AHF), .H_SYNC(AHS),
        .H_BACK_PORCH(AHB), .V_FRONT_PORCH(AVF), .V_SYNC(AVS),
        .V_BACK_PORCH(AVB), .CLK_DIV(ACD)
    ) u_a (
        .clk(clk), .rst_n(rst_a_n), .enable(en_a), .fetch_ack(ack_a),
        .underrun_clear(clr_a), .pixel_tick(tick_a),
        .pixel_position_x(xa), .pixel_position_y(ya),
        .line_start(ls_a), .frame_start(fs_a), .fetch_req(req_a),
        .fetch_line(line_a), .underrun_flag(uf_a), .running(run_a)
    );

    vga_scan_controller #(
        .X_RES(BXR), .Y_RES(BYR), .H_FRONT_PORCH(1), .H_SYNC(1),
        .H_BACK_PORCH(1), .V_FRONT_PORCH(1), .V_SYNC(1),
        .V_BACK_PORCH(1), .CLK_DIV(BCD)
    ) u_b (
        .clk(clk), .rst_n(rst_b_n), .enable(en_b), .fetch_ack(ack_b),
        .underrun_clear(clr_b), .pixel_tick(tick_b),
        .pixel_position_x(xb), .pixel_position_y(yb),
        .line_start(ls_b), .frame_start(fs_b), .fetch_req(req_b),
        .fetch_line(line_b), .underrun_flag(uf_b), .running(run_b)
    );

    int n_chk = 0;
    int n_fail = 0;

    tick_t  qa_tick[$], qb_tick[$];
    fetch_t qa_fetch[$], qb_fetch[$];

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Expected raster for n ticks from the origin; line-0 prefetch only before no_l0
    task automatic push_exp(input bit b, input int n, input int no_l0,
                            input int ht, input int vt, input int xr, input int yr);
        for (int k = 0; k < n; k++) begin
            int     x;
            int     y;
            tick_t  t;
            fetch_t f;
            x    = k % ht;
            y    = (k / ht) % vt;
            t.x  = 10'(x);
            t.y  = 10'(y);
            t.ls = (x == 0) && (y < yr);
            t.fs = (x == 0) && (y == 0);
            if (b) qb_tick.push_back(t);
            else   qa_tick.push_back(t);
            if (x == xr) begin
                f.y = 10'(y);
                if (y + 1 < yr) begin
                    f.line = 10'(y + 1);
                    if (b) qb_fetch.push_back(f);
                    else   qa_fetch.push_back(f);
                end else if ((y == vt - 1) && (k < no_l0)) begin
                    f.line = '0;
                    if (b) qb_fetch.push_back(f);
                    else   qa_fetch.push_back(f);
                end
            end
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    bit a_ack_mode = 1'b0;
    int a_epoch = 0, a_start = 0, b_epoch = 0, b_start = 0;

    int   ma_seen = 0, ma_last = 0, ma_wait = 0;
    logic req_a_q = 1'b0;
    always @(negedge clk) begin
        tick_t  t;
        fetch_t f;
        if (ack_a) begin
            ack_a = 1'b0;
            check("a_req_drop", int'(req_a), 0);
        end else if (ma_wait > 0) begin
            ma_wait--;
            if (ma_wait == 0) ack_a = 1'b1;
        end
        if (tick_a) begin
            if (ma_seen != a_epoch) begin
                ma_seen = a_epoch;
                ma_last = a_start;
            end
            check("a_tick_gap", cyc - ma_last, ACD);
            ma_last = cyc;
            if (qa_tick.size() == 0) begin
                check("a_extra_tick", int'(tick_a), 0);
            end else begin
                t = qa_tick.pop_front();
                check("a_x", int'(xa), int'(t.x));
                check("a_y", int'(ya), int'(t.y));
                check("a_line_start", int'(ls_a), int'(t.ls));
                check("a_frame_start", int'(fs_a), int'(t.fs));
            end
        end else begin
            if (ls_a || fs_a) check("a_pulse_no_tick", int'(ls_a | fs_a), 0);
        end
        if (req_a && !req_a_q) begin
            if (qa_fetch.size() == 0) begin
                check("a_extra_fetch", int'(req_a), 0);
            end else begin
                f = qa_fetch.pop_front();
                check("a_fetch_line", int'(line_a), int'(f.line));
                check("a_fetch_y", int'(ya), int'(f.y));
                check("a_fetch_x", int'(xa), AXR);
            end
            if (a_ack_mode) ma_wait = 3;
        end
        req_a_q = req_a;
    end

    int   mb_seen = 0, mb_last = 0;
    logic req_b_q = 1'b0;
    always @(negedge clk) begin
        tick_t  t;
        fetch_t f;
        if (ack_b) check("b_req_drop", int'(req_b), 0);
        if (tick_b) begin
            if (mb_seen != b_epoch) begin
                mb_seen = b_epoch;
                mb_last = b_start;
            end
            check("b_tick_gap", cyc - mb_last, BCD);
            mb_last = cyc;
            if (qb_tick.size() == 0) begin
                check("b_extra_tick", int'(tick_b), 0);
            end else begin
                t = qb_tick.pop_front();
                check("b_x", int'(xb), int'(t.x));
                check("b_y", int'(yb), int'(t.y));
                check("b_line_start", int'(ls_b), int'(t.ls));
                check("b_frame_start", int'(fs_b), int'(t.fs));
            end
        end
        if (req_b && !req_b_q) begin
            if (qb_fetch.size() == 0) begin
                check("b_extra_fetch", int'(req_b), 0);
            end else begin
                f = qb_fetch.pop_front();
                check("b_fetch_line", int'(line_b), int'(f.line));
                check("b_fetch_y", int'(yb), int'(f.y));
                check("b_fetch_x", int'(xb), BXR);
            end
        end
        req_b_q = req_b;
        // line 0 is only acknowledged in the frame_start cycle itself
        ack_b = req_b && ((line_b != 10'd0) || fs_b);
    end

    task automatic check_a_zero(input string tag);
        check({tag, "_tick"}, int'(tick_a), 0);
        check({tag, "_x"}, int'(xa), 0);
        check({tag, "_y"}, int'(ya), 0);
        check({tag, "_ls"}, int'(ls_a), 0);
        check({tag, "_fs"}, int'(fs_a), 0);
        check({tag, "_req"}, int'(req_a), 0);
        check({tag, "_uf"}, int'(uf_a), 0);
        check({tag, "_run"}, int'(run_a), 0);
    endtask

    initial begin
        int n;
        int ln;
        rst_a_n = 1'b0; en_a = 1'b0; ack_a = 1'b0; clr_a = 1'b0;
        rst_b_n = 1'b0; en_b = 1'b0; ack_b = 1'b0; clr_b = 1'b0;
        step();
        step();
        check_a_zero("a_rst");
        check("a_rst_line", int'(line_a), 0);
        check("b_rst_run", int'(run_b), 0);
        check("b_rst_tick", int'(tick_b), 0);
        rst_a_n = 1'b1;
        rst_b_n = 1'b1;
        step();
        step();
        check_a_zero("a_idle");

        push_exp(1'b0, 4 * AFR, 3 * AFR, AHT, AVT, AXR, AYR);
        a_ack_mode = 1'b1;
        a_start    = cyc + 1;
        a_epoch++;
        en_a = 1'b1;
        step();
        check("a_run_entry", int'(run_a), 1);

        n = 0;
        while (qa_tick.size() >= 2 * AFR && n < 3 * AFR * ACD) begin
            step();
            n++;
        end
        check("a_reach_frame2", int'(n < 3 * AFR * ACD), 1);
        check("a_no_underrun_acked", int'(uf_a), 0);
        a_ack_mode = 1'b0;

        n = 0;
        while (!req_a && n < 200) begin step(); n++; end
        check("a_reach_req1", int'(n < 200), 1);
        ln = int'(line_a);
        check("a_ur_line", ln, 1);
        n = 0;
        while (!(ls_a && ya == 10'(ln)) && n < 200) begin step(); n++; end
        check("a_reach_ls1", int'(n < 200), 1);
        step();
        check("a_ur_req_drop", int'(req_a), 0);
        check("a_ur_flag", int'(uf_a), 1);
        clr_a = 1'b1;
        step();
        clr_a = 1'b0;
        check("a_ur_cleared", int'(uf_a), 0);

        n = 0;
        while (!req_a && n < 200) begin step(); n++; end
        check("a_reach_req2", int'(n < 200), 1);
        ln = int'(line_a);
        n = 0;
        while (!(ls_a && ya == 10'(ln)) && n < 200) begin step(); n++; end
        check("a_reach_ls2", int'(n < 200), 1);
        clr_a = 1'b1;
        step();
        clr_a = 1'b0;
        check("a_ur_set_wins", int'(uf_a), 1);
        check("a_ur2_req_drop", int'(req_a), 0);
        a_ack_mode = 1'b1;

        n = 0;
        while (ya != 10'd3 && n < 400) begin step(); n++; end
        check("a_reach_y3", int'(n < 400), 1);
        en_a = 1'b0;
        step();
        check("a_stopping_running", int'(run_a), 1);
        n = 0;
        while (ya != 10'd5 && n < 400) begin step(); n++; end
        check("a_reach_y5", int'(n < 400), 1);
        en_a = 1'b1;
        step();
        check("a_resume_running", int'(run_a), 1);

        n = 0;
        while (!(qa_tick.size() < AFR && ya == 10'd2) && n < 3 * AFR * ACD) begin
            step();
            n++;
        end
        check("a_reach_last_frame", int'(n < 3 * AFR * ACD), 1);
        en_a = 1'b0;
        n = 0;
        while (run_a && n < AFR * ACD + 20) begin step(); n++; end
        check("a_reach_idle", int'(n < AFR * ACD + 20), 1);
        check("a_stop_x", int'(xa), 0);
        check("a_stop_y", int'(ya), 0);
        check("a_stop_req", int'(req_a), 0);
        check("a_stop_tick", int'(tick_a), 0);
        check("a_tick_q_left", qa_tick.size(), 0);
        check("a_fetch_q_left", qa_fetch.size(), 0);
        repeat (10) step();
        check("a_idle_hold_tick", int'(tick_a), 0);
        check("a_idle_hold_run", int'(run_a), 0);

        push_exp(1'b0, AFR, AFR, AHT, AVT, AXR, AYR);
        a_start = cyc + 1;
        a_epoch++;
        en_a = 1'b1;
        n = 0;
        while (!(ya == 10'd3 && xa == 10'd10) && n < AFR * ACD) begin
            step();
            n++;
        end
        check("a_reach_mid", int'(n < AFR * ACD), 1);
        rst_a_n = 1'b0;
        #1;
        check_a_zero("a_async_rst");
        qa_tick.delete();
        qa_fetch.delete();
        step();
        push_exp(1'b0, 30, 30, AHT, AVT, AXR, AYR);
        a_start = cyc + 1;
        a_epoch++;
        rst_a_n = 1'b1;
        n = 0;
        while (qa_tick.size() != 0 && n < 100) begin step(); n++; end
        check("a_restart_ticks", int'(n < 100), 1);
        check("a_restart_fetch_q", qa_fetch.size(), 0);
        rst_a_n = 1'b0;
        en_a = 1'b0;
        step();
        rst_a_n = 1'b1;

        push_exp(1'b1, 2 * BFR, BFR, BHT, BVT, BXR, BYR);
        b_start = cyc + 1;
        b_epoch++;
        en_b = 1'b1;
        n = 0;
        while (qb_tick.size() >= BFR && n < 200) begin step(); n++; end
        check("b_reach_frame2", int'(n < 200), 1);
        en_b = 1'b0;
        n = 0;
        while (run_b && n < 200) begin step(); n++; end
        check("b_reach_idle", int'(n < 200), 1);
        check("b_l0_ack_on_fs", int'(uf_b), 0);
        check("b_stop_x", int'(xb), 0);
        check("b_stop_y", int'(yb), 0);
        check("b_tick_q_left", qb_tick.size(), 0);
        check("b_fetch_q_left", qb_fetch.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
